// File: rtl/wdt_rst_ctrl.sv
// Watchdog reset controller: turns overflow events into a warning interrupt,
// then a fixed-length active-low reset request if the warning goes unserviced.
module wdt_rst_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       ovf_i,
  input  logic       kick_i,
  output logic       irq_o,
  output logic       wdt_rst_no,
  output logic       counter_clr_o,
  output logic [1:0] state_o,
  output logic [7:0] ovf_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WARN  = 2'd2,
    ST_RESET = 2'd3
  } state_e;

  localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE_CYCLES);

  state_e     state_q, state_d;
  logic       ovf_q, ovf_d;
  logic       irq_q, irq_d;
  logic       rst_n_q, rst_n_d;
  logic       clr_q, clr_d;
  logic [7:0] pulse_q, pulse_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ovf_evt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b1;
      irq_q   <= 1'b0;
      rst_n_q <= 1'b1;
      clr_q   <= 1'b0;
      pulse_q <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
      rst_n_q <= rst_n_d;
      clr_q   <= clr_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  // ovf_q resets high so a flag already asserted at reset release is not an edge.
  assign ovf_evt = ovf_i & ~ovf_q;

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_i;
    irq_d   = irq_q;
    rst_n_d = rst_n_q;
    clr_d   = 1'b0;
    pulse_d = pulse_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_ARMED;
          clr_d   = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (kick_i) begin
          clr_d = 1'b1;
        end else if (ovf_evt) begin
          state_d = ST_WARN;
          irq_d   = 1'b1;
        end
      end
      ST_WARN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end else if (kick_i) begin
          state_d = ST_ARMED;
          irq_d   = 1'b0;
          clr_d   = 1'b1;
        end else if (ovf_evt) begin
          state_d = ST_RESET;
          pulse_d = PULSE_LOAD;
          rst_n_d = 1'b0;
        end
      end
      ST_RESET: begin
        // The <= guard keeps a zero count from wrapping into a 255-cycle pulse.
        if (pulse_q <= 8'd1) begin
          state_d = ST_IDLE;
          rst_n_d = 1'b1;
          irq_d   = 1'b0;
          clr_d   = 1'b1;
          pulse_d = 8'd0;
        end else begin
          pulse_d = pulse_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ovf_evt && (state_q != ST_IDLE) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign irq_o         = irq_q;
  assign wdt_rst_no    = rst_n_q;
  assign counter_clr_o = clr_q;
  assign state_o       = state_q;
  assign ovf_cnt_o     = cnt_q;

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Scoreboard bench for wdt_rst_ctrl: directed stimulus queues hand-computed
// expectations tagged with a cycle number; a negedge monitor checks them.
module tb_wdt_rst_ctrl;

  localparam int F_IRQ   = 0;
  localparam int F_RSTN  = 1;
  localparam int F_CLR   = 2;
  localparam int F_STATE = 3;
  localparam int F_CNT   = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       ovf_i;
  logic       kick_i;
  logic       irq_o;
  logic       wdt_rst_no;
  logic       counter_clr_o;
  logic [1:0] state_o;
  logic [7:0] ovf_cnt_o;

  typedef struct {
    int         cyc;
    int         fld;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  wdt_rst_ctrl #(.RST_PULSE_CYCLES(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .ovf_i         (ovf_i),
    .kick_i        (kick_i),
    .irq_o         (irq_o),
    .wdt_rst_no    (wdt_rst_no),
    .counter_clr_o (counter_clr_o),
    .state_o       (state_o),
    .ovf_cnt_o     (ovf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [7:0] field_val(input int f);
    case (f)
      F_IRQ:   return {7'd0, irq_o};
      F_RSTN:  return {7'd0, wdt_rst_no};
      F_CLR:   return {7'd0, counter_clr_o};
      F_STATE: return {6'd0, state_o};
      default: return ovf_cnt_o;
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_IRQ:   return "irq_o";
      F_RSTN:  return "wdt_rst_no";
      F_CLR:   return "counter_clr_o";
      F_STATE: return "state_o";
      default: return "ovf_cnt_o";
    endcase
  endfunction

  task automatic expect_at(input int c, input int f, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: checks every queued expectation whose cycle has arrived.
  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [7:0] act;
        act = field_val(sb[i].fld);
        n_checks++;
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                   fname(sb[i].fld), sb[i].cyc, act, sb[i].val);
        end else begin
          $display("check %s cyc=%0d value=%0d ok", fname(sb[i].fld), cyc, act);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Reset release with ovf_i and en_i already high.
    rst_ni = 1'b0;
    en_i   = 1'b1;
    ovf_i  = 1'b1;
    kick_i = 1'b0;
    tick();
    tick();
    expect_at(cyc, F_IRQ, 8'd0);
    expect_at(cyc, F_RSTN, 8'd1);
    expect_at(cyc, F_CLR, 8'd0);
    expect_at(cyc, F_STATE, 8'd0);
    expect_at(cyc, F_CNT, 8'd0);
    rst_ni = 1'b1;
    expect_at(cyc + 1, F_STATE, 8'd1);
    expect_at(cyc + 1, F_CLR, 8'd1);
    expect_at(cyc + 1, F_CNT, 8'd0);
    expect_at(cyc + 2, F_CLR, 8'd0);
    expect_at(cyc + 2, F_STATE, 8'd1);
    tick();
    tick();
    tick();
    ovf_i = 1'b0;
    expect_at(cyc + 1, F_STATE, 8'd1);
    expect_at(cyc + 1, F_IRQ, 8'd0);
    expect_at(cyc + 1, F_CNT, 8'd0);
    tick();
    tick();

    // ARMED, overflow flag two cycles wide -> one event, WARN.
    ovf_i = 1'b1;
    expect_at(cyc + 1, F_IRQ, 8'd1);
    expect_at(cyc + 1, F_STATE, 8'd2);
    expect_at(cyc + 1, F_CNT, 8'd1);
    tick();
    expect_at(cyc + 1, F_CNT, 8'd1);
    expect_at(cyc + 1, F_STATE, 8'd2);
    tick();
    ovf_i = 1'b0;
    tick();
    tick();

    // WARN, kick and overflow together: kick wins, event still counted.
    kick_i = 1'b1;
    ovf_i  = 1'b1;
    expect_at(cyc + 1, F_STATE, 8'd1);
    expect_at(cyc + 1, F_IRQ, 8'd0);
    expect_at(cyc + 1, F_CLR, 8'd1);
    expect_at(cyc + 1, F_RSTN, 8'd1);
    expect_at(cyc + 1, F_CNT, 8'd2);
    tick();
    kick_i = 1'b0;
    ovf_i  = 1'b0;
    expect_at(cyc + 1, F_CLR, 8'd0);
    expect_at(cyc + 1, F_STATE, 8'd1);
    tick();
    tick();

    // Full 16-cycle reset pulse with ignored kick/en/ovf activity inside it.
    ovf_i = 1'b1;
    expect_at(cyc + 1, F_STATE, 8'd2);
    expect_at(cyc + 1, F_IRQ, 8'd1);
    expect_at(cyc + 1, F_CNT, 8'd3);
    tick();
    ovf_i = 1'b0;
    tick();
    tick();
    n = cyc;
    ovf_i = 1'b1;
    expect_at(n + 1, F_RSTN, 8'd0);
    expect_at(n + 1, F_STATE, 8'd3);
    expect_at(n + 1, F_CNT, 8'd4);
    expect_at(n + 1, F_IRQ, 8'd1);
    expect_at(n + 6, F_STATE, 8'd3);
    expect_at(n + 6, F_RSTN, 8'd0);
    expect_at(n + 8, F_STATE, 8'd3);
    expect_at(n + 8, F_RSTN, 8'd0);
    expect_at(n + 10, F_CNT, 8'd5);
    expect_at(n + 10, F_RSTN, 8'd0);
    expect_at(n + 16, F_RSTN, 8'd0);
    expect_at(n + 16, F_IRQ, 8'd1);
    expect_at(n + 16, F_STATE, 8'd3);
    expect_at(n + 17, F_RSTN, 8'd1);
    expect_at(n + 17, F_STATE, 8'd0);
    expect_at(n + 17, F_IRQ, 8'd0);
    expect_at(n + 17, F_CLR, 8'd1);
    expect_at(n + 18, F_STATE, 8'd1);
    expect_at(n + 18, F_CLR, 8'd1);
    expect_at(n + 18, F_CNT, 8'd5);
    expect_at(n + 19, F_CLR, 8'd0);
    expect_at(n + 19, F_STATE, 8'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      case (k)
        1:  ovf_i  = 1'b0;
        3:  en_i   = 1'b0;
        6:  en_i   = 1'b1;
        7:  kick_i = 1'b1;
        8:  kick_i = 1'b0;
        9:  ovf_i  = 1'b1;
        10: ovf_i  = 1'b0;
        default: ;
      endcase
    end

    // Reset asserted five cycles into the pulse truncates it.
    ovf_i = 1'b1;
    expect_at(cyc + 1, F_STATE, 8'd2);
    expect_at(cyc + 1, F_CNT, 8'd6);
    tick();
    ovf_i = 1'b0;
    tick();
    tick();
    n = cyc;
    ovf_i = 1'b1;
    expect_at(n + 1, F_RSTN, 8'd0);
    expect_at(n + 1, F_CNT, 8'd7);
    expect_at(n + 5, F_RSTN, 8'd0);
    expect_at(n + 5, F_STATE, 8'd3);
    expect_at(n + 6, F_RSTN, 8'd1);
    expect_at(n + 6, F_STATE, 8'd0);
    expect_at(n + 6, F_CNT, 8'd0);
    expect_at(n + 6, F_IRQ, 8'd0);
    expect_at(n + 6, F_CLR, 8'd0);
    expect_at(n + 8, F_STATE, 8'd1);
    expect_at(n + 8, F_CLR, 8'd1);
    expect_at(n + 8, F_CNT, 8'd0);
    tick();
    ovf_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    tick();

    // 300 events with kicks in between: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      ovf_i = 1'b1;
      expect_at(cyc + 1, F_CNT, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      expect_at(cyc + 1, F_STATE, 8'd2);
      tick();
      ovf_i = 1'b0;
      tick();
      kick_i = 1'b1;
      expect_at(cyc + 1, F_STATE, 8'd1);
      expect_at(cyc + 1, F_IRQ, 8'd0);
      tick();
      kick_i = 1'b0;
      tick();
    end

    // Disable from ARMED, then overflows in IDLE are not counted.
    en_i = 1'b0;
    expect_at(cyc + 1, F_STATE, 8'd0);
    tick();
    tick();
    for (int j = 0; j < 3; j++) begin
      ovf_i = 1'b1;
      expect_at(cyc + 1, F_CNT, 8'd255);
      expect_at(cyc + 1, F_STATE, 8'd0);
      tick();
      ovf_i = 1'b0;
      tick();
      tick();
    end

    // Disable from WARN clears the interrupt.
    en_i = 1'b1;
    expect_at(cyc + 1, F_STATE, 8'd1);
    tick();
    ovf_i = 1'b1;
    expect_at(cyc + 1, F_STATE, 8'd2);
    expect_at(cyc + 1, F_IRQ, 8'd1);
    tick();
    ovf_i = 1'b0;
    en_i  = 1'b0;
    expect_at(cyc + 1, F_STATE, 8'd0);
    expect_at(cyc + 1, F_IRQ, 8'd0);
    expect_at(cyc + 1, F_RSTN, 8'd1);
    tick();
    tick();
    tick();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover actual=%0d pending required=0 pending", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wdt_rst_ctrl.md
# wdt_rst_ctrl

Watchdog reset controller sitting directly downstream of the watchdog overflow detector. Turns the detector's overflow flag into a two-stage response: first overflow raises a warning interrupt, a second unserviced overflow drives a fixed-length, active-low reset request to the SoC reset unit. Software service ("kick") clears the warning and tells the upstream watchdog counter to restart.

## Interface
- RST_PULSE_CYCLES, 16, length of the reset request pulse in clk_i cycles; legal range 1..255
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- en_i  in  1  watchdog enable (level, from config register)
- ovf_i  in  1  overflow flag from the overflow detector; high for 1 or 2 consecutive cycles per counter wrap
- kick_i  in  1  software service strobe, single-cycle
- irq_o  out  1  warning interrupt, level
- wdt_rst_no  out  1  reset request, active-low
- counter_clr_o  out  1  single-cycle clear strobe to the upstream watchdog counter
- state_o  out  2  FSM state: 0 IDLE, 1 ARMED, 2 WARN, 3 RESET
- ovf_cnt_o  out  8  saturating count of overflow events seen while enabled

## Operation
- Event extraction: ovf_q registers ovf_i; ovf_evt = ovf_i & ~ovf_q. A 1- or 2-cycle-wide ovf_i yields exactly one event. ovf_q resets to 1, so an ovf_i already high at reset release is not an event.
- FSM, evaluated every cycle, priority en_i low > kick_i > ovf_evt:
  - IDLE: en_i=1 -> ARMED, pulse counter_clr_o.
  - ARMED: en_i=0 -> IDLE. kick_i -> stay, pulse counter_clr_o. ovf_evt -> WARN, set irq_o.
  - WARN: en_i=0 -> IDLE, clear irq_o. kick_i -> ARMED, clear irq_o, pulse counter_clr_o (kick wins over a simultaneous ovf_evt). ovf_evt -> RESET, load pulse counter with RST_PULSE_CYCLES, drive wdt_rst_no low.
  - RESET: en_i, kick_i, ovf_evt ignored. Pulse counter decrements each cycle; on reaching 1 -> IDLE, release wdt_rst_no, clear irq_o, pulse counter_clr_o.
- ovf_cnt_o: increments by 1 on every ovf_evt while state != IDLE (including RESET); saturates at 255; cleared only by rst_ni.
- Pulse counter width: 8 bits, unsigned; no wrap (reload only on entering RESET).

## Timing
- All outputs registered; no combinational input-to-output path.
- Reset values: state IDLE, irq_o=0, wdt_rst_no=1, counter_clr_o=0, state_o=0, ovf_cnt_o=0, ovf_q=1, pulse counter 0.
- ovf_i rising in cycle N (ARMED) -> irq_o=1, state_o=2 in cycle N+1.
- ovf_i rising in cycle N (WARN) -> wdt_rst_no=0 from N+1 through N+RST_PULSE_CYCLES inclusive, high again at N+RST_PULSE_CYCLES+1; irq_o stays 1 until that same cycle.
- kick_i in cycle N (ARMED/WARN) -> counter_clr_o=1 in N+1 only; irq_o=0 in N+1.
- en_i rising in cycle N (IDLE) -> state ARMED, counter_clr_o=1 in N+1.
- After RESET exit, en_i still high -> IDLE one cycle, ARMED the next with a second counter_clr_o pulse.
- rst_ni low mid-RESET: outputs return to reset values on the next clock edge; pulse is truncated, not resumed.
- ovf_i held high continuously: one event only; no re-trigger until ovf_i has been low for at least one cycle.

## Test plan
- Reset release with ovf_i=1, en_i=1: no event counted; ovf_cnt_o=0, state ARMED after 1 cycle, counter_clr_o single pulse.
- ARMED, ovf_i high 2 cycles: irq_o=1 next cycle, ovf_cnt_o=1 (not 2), state_o=2.
- WARN, kick_i and ovf_i rising same cycle: state ARMED, irq_o=0, counter_clr_o=1 for one cycle, wdt_rst_no stays 1, ovf_cnt_o incremented.
- WARN, second overflow, RST_PULSE_CYCLES=16: wdt_rst_no low exactly 16 cycles; kick_i and en_i=0 during pulse ignored; then IDLE, irq_o=0, counter_clr_o pulse.
- rst_ni asserted 5 cycles into reset pulse: next edge wdt_rst_no=1, state_o=0, ovf_cnt_o=0.
- 300 overflow events in ARMED/WARN with kicks between: ovf_cnt_o saturates at 255; en_i=0 then further ovf_i pulses leave count unchanged.
